// File: rtl/sysbus_pkg.sv
//--------------------------------------------------------------------------
// Module      : sysbus_pkg
// Description : Shared types and constants for the sysbus memory responder:
//               responder state encoding, request-tag field positions,
//               the MEMORY access type and the burst length.
// Revision    : 1.0 - initial release
//--------------------------------------------------------------------------
`default_nettype none

package sysbus_pkg;

    // Responder control states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_DATA  = 2'd1,
        WAIT_LAT = 2'd2,
        RESP     = 2'd3
    } state_t;

    // Request tag layout: [12] read/write, [11:8] access type
    localparam int c_TAG_RW_BIT  = 12;
    localparam int c_TAG_TYPE_HI = 11;
    localparam int c_TAG_TYPE_LO = 8;

    // Access type that targets the backing store
    localparam logic [3:0] MEMORY = 4'b0001;

    // One line is eight 64-bit words (64 bytes)
    localparam int BEATS_PER_LINE     = 8;
    localparam int c_WORD_OFFSET_BITS = 3;
    localparam int c_LINE_OFFSET_BITS = 6;

    // True when the tag's type field selects the backing store
    function automatic logic tag_is_memory(input logic [3:0] tag_type);
        return tag_type == MEMORY;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sysbus_mem_array.sv
//--------------------------------------------------------------------------
// Module      : sysbus_mem_array
// Description : Single-port backing store: synchronous write, combinational
//               read on the same address. Contents are never reset.
// Revision    : 1.0 - initial release
//--------------------------------------------------------------------------
`default_nettype none

module sysbus_mem_array #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write port: one word per enabled clock edge
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/sysbus_mem_responder.sv
//--------------------------------------------------------------------------
// Module      : sysbus_mem_responder
// Description : System-bus slave serving 8-beat line bursts from a local
//               store. Reads answer RESP_LATENCY cycles after acceptance;
//               writes take eight data beats and produce no response.
//               Optional macro SYSBUS_ADDR_CHECK_EN: out-of-range lines
//               read as all-ones and drop writes; otherwise addresses wrap.
// Revision    : 1.0 - initial release
//--------------------------------------------------------------------------
`default_nettype none

module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int RESP_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack,
    output logic                      busy
);

    localparam int         c_AW        = $clog2(MEM_WORDS);
    localparam int         c_LINE_AW   = c_AW - c_WORD_OFFSET_BITS;
    localparam logic [2:0] c_LAST_BEAT = 3'(BEATS_PER_LINE - 1);
    localparam logic [3:0] c_LAT_LAST  = 4'(RESP_LATENCY - 1);

    state_t                    r_state;
    state_t                    w_next_state;
    logic [2:0]                r_beat;
    logic [3:0]                r_lat_cnt;
    logic [c_LINE_AW-1:0]      r_line_idx;
    logic [BUS_TAG_WIDTH-1:0]  r_tag;
    logic                      r_is_mem;
    logic                      r_oor;

    logic                      w_req_is_mem;
    logic                      w_req_oor;
    logic                      w_mem_we;
    logic [c_AW-1:0]           w_mem_addr;
    logic [BUS_DATA_WIDTH-1:0] w_mem_rdata;

    assign w_req_is_mem = tag_is_memory(bus_reqtag[c_TAG_TYPE_HI:c_TAG_TYPE_LO]);

`ifdef SYSBUS_ADDR_CHECK_EN
    // A line is out of range when any word-index bit above the store depth is set
    generate
        if (BUS_DATA_WIDTH > c_AW + c_WORD_OFFSET_BITS) begin : g_range_chk
            assign w_req_oor = |bus_req[BUS_DATA_WIDTH-1:c_AW+c_WORD_OFFSET_BITS];
        end else begin : g_range_all_ok
            assign w_req_oor = 1'b0;
        end
    endgenerate
`else
    assign w_req_oor = 1'b0;
`endif

    // Line bases are 8-word aligned, so the beat simply fills the low index bits
    assign w_mem_addr = {r_line_idx, r_beat};
    assign w_mem_we   = (r_state == WR_DATA) && bus_reqcyc && r_is_mem && !r_oor;

    sysbus_mem_array #(
        .DATA_WIDTH (BUS_DATA_WIDTH),
        .DEPTH      (MEM_WORDS),
        .ADDR_WIDTH (c_AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (bus_req),
        .o_rdata (w_mem_rdata)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus_reqcyc) begin
                    w_next_state = bus_reqtag[c_TAG_RW_BIT] ? WAIT_LAT : WR_DATA;
                end
            end
            WR_DATA: begin
                if (bus_reqcyc && (r_beat == c_LAST_BEAT)) begin
                    w_next_state = IDLE;
                end
            end
            WAIT_LAT: begin
                if (r_lat_cnt == c_LAT_LAST) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (bus_respack && (r_beat == c_LAST_BEAT)) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Request capture, beat and latency counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_beat     <= '0;
            r_lat_cnt  <= '0;
            r_line_idx <= '0;
            r_tag      <= '0;
            r_is_mem   <= 1'b0;
            r_oor      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus_reqcyc) begin
                        r_line_idx <= bus_req[c_AW+c_WORD_OFFSET_BITS-1:c_LINE_OFFSET_BITS];
                        r_tag      <= bus_reqtag;
                        r_is_mem   <= w_req_is_mem;
                        r_oor      <= w_req_oor;
                        r_beat     <= '0;
                        r_lat_cnt  <= '0;
                    end
                end
                WR_DATA: begin
                    if (bus_reqcyc) begin
                        r_beat <= r_beat + 3'd1;
                    end
                end
                WAIT_LAT: begin
                    r_beat <= '0;
                    if (r_lat_cnt == c_LAT_LAST) begin
                        r_lat_cnt <= '0;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 4'd1;
                    end
                end
                RESP: begin
                    if (bus_respack) begin
                        r_beat <= r_beat + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus outputs decoded from state; reset masks the combinational ack path
    always_comb begin
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        bus_resptag = '0;
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE:    bus_reqack = bus_reqcyc && reset;
            WR_DATA: bus_reqack = bus_reqcyc;
            RESP: begin
                bus_respcyc = 1'b1;
                bus_resptag = r_tag;
                if (!r_is_mem) begin
                    bus_resp = '0;
                end else if (r_oor) begin
                    bus_resp = '1;
                end else begin
                    bus_resp = w_mem_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_sysbus_mem_responder.sv
//--------------------------------------------------------------------------
// Module      : tb_sysbus_mem_responder
// Description : Self-checking bench for sysbus_mem_responder. A word-array
//               model of the store plus transaction-level burst rules set
//               the expected outputs for each cycle; literal pins anchor
//               chosen beats. Honours SYSBUS_ADDR_CHECK_EN when defined.
// Revision    : 1.0 - initial release
//--------------------------------------------------------------------------
`default_nettype none

module tb_sysbus_mem_responder;

    localparam int MW  = 4096;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bus_reqcyc = 1'b0;
    logic [63:0] bus_req = '0;
    logic [12:0] bus_reqtag = '0;
    logic        bus_respack = 1'b0;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        busy;

    always #5 clk = ~clk;

    sysbus_mem_responder #(
        .BUS_DATA_WIDTH (64),
        .BUS_TAG_WIDTH  (13),
        .MEM_WORDS      (MW),
        .RESP_LATENCY   (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack),
        .busy        (busy)
    );

    logic [63:0] model_mem [MW];

    logic        chk_en = 1'b0;
    logic        exp_ack = 1'b0;
    logic        exp_rcyc = 1'b0;
    logic        exp_busy = 1'b0;
    logic [63:0] exp_resp = '0;
    logic [12:0] exp_tag = '0;
    logic        pin_en = 1'b0;
    logic [63:0] pin_val = '0;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    endtask

    // Per-cycle compare against the expectations set for the current cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("reqack", 64'(bus_reqack), 64'(exp_ack));
            chk("respcyc", 64'(bus_respcyc), 64'(exp_rcyc));
            chk("busy", 64'(busy), 64'(exp_busy));
            if (exp_rcyc || !reset) begin
                chk("resp", bus_resp, exp_resp);
                chk("resptag", 64'(bus_resptag), 64'(exp_tag));
            end
            if (pin_en) begin
                chk("pin_resp", bus_resp, pin_val);
                chk("pin_model", exp_resp, pin_val);
            end
        end
    end

    function automatic int line_word(input logic [63:0] a);
        return int'(((a >> 3) & ~64'd7) % 64'(MW));
    endfunction

    function automatic bit out_of_range(input logic [63:0] a);
`ifdef SYSBUS_ADDR_CHECK_EN
        return (a >> 3) >= 64'(MW);
`else
        return (a >> 3) != (a >> 3) + 64'd1 && 1'b0;
`endif
    endfunction

    function automatic bit is_mem(input logic [12:0] tg);
        return tg[11:8] == 4'b0001;
    endfunction

    function automatic logic [63:0] beat_data(input logic [63:0] a, input logic [12:0] tg, input int b);
        if (!is_mem(tg)) return '0;
        if (out_of_range(a)) return '1;
        return model_mem[line_word(a) + b];
    endfunction

    // One bus cycle: drive inputs just after the rising edge, state expectations
    task automatic cyc(input logic rn, input logic rc, input logic [63:0] rq, input logic [12:0] tg,
                       input logic ra, input logic e_ack, input logic e_rcyc, input logic [63:0] e_resp,
                       input logic [12:0] e_tag, input logic e_busy);
        @(posedge clk);
        #1;
        reset = rn; bus_reqcyc = rc; bus_req = rq; bus_reqtag = tg; bus_respack = ra;
        exp_ack = e_ack; exp_rcyc = e_rcyc; exp_resp = e_resp; exp_tag = e_tag; exp_busy = e_busy;
        pin_en = 1'b0; chk_en = 1'b1;
    endtask

    // Address beat then eight data beats; optional idle gap and reset abort
    task automatic do_write(input logic [63:0] addr, input logic [12:0] tg, input logic [63:0] seed,
                            input int gap_at, input int abort_at);
        logic [63:0] d;
        cyc(1, 1, addr, tg, 0, 1, 0, '0, '0, 0);
        for (int i = 0; i < 8; i++) begin
            d = seed * 64'(i + 1);
            if (i == gap_at) cyc(1, 0, 64'hFFFF, tg, 0, 0, 0, '0, '0, 1);
            if (i == abort_at) begin
                cyc(0, 1, d, tg, 0, 0, 0, '0, '0, 0);
                cyc(1, 0, '0, '0, 0, 0, 0, '0, '0, 0);
                return;
            end
            cyc(1, 1, d, tg, 0, 1, 0, '0, '0, 1);
            if (is_mem(tg) && !out_of_range(addr)) model_mem[line_word(addr) + i] = d;
        end
    endtask

    // Read burst: latency wait (respack toggled to show it is ignored), eight beats,
    // optional stall, optional competing request held through the burst, two pins
    task automatic do_read(input logic [63:0] addr, input logic [12:0] tg,
                           input int stall_beat, input int stall_len,
                           input logic hold_next, input logic [63:0] naddr, input logic [12:0] ntag,
                           input int pa, input logic [63:0] va, input int pb, input logic [63:0] vb);
        logic [63:0] d;
        cyc(1, 1, addr, tg, 0, 1, 0, '0, '0, 0);
        for (int w = 0; w < LAT; w++) cyc(1, hold_next, naddr, ntag, 1, 0, 0, '0, '0, 1);
        for (int b = 0; b < 8; b++) begin
            d = beat_data(addr, tg, b);
            if (b == stall_beat)
                for (int s = 0; s < stall_len; s++) cyc(1, hold_next, naddr, ntag, 0, 0, 1, d, tg, 1);
            cyc(1, hold_next, naddr, ntag, 1, 0, 1, d, tg, 1);
            if (b == pa) begin pin_en = 1'b1; pin_val = va; end
            if (b == pb) begin pin_en = 1'b1; pin_val = vb; end
        end
        if (!hold_next) cyc(1, 0, '0, '0, 1, 0, 0, '0, '0, 0);
    endtask

    initial begin
        // Reset held with a request pending: everything must stay quiet
        for (int i = 0; i < 3; i++) cyc(0, 1, 64'h40, 13'h1100, 1, 0, 0, '0, '0, 0);
        cyc(1, 0, '0, '0, 0, 0, 0, '0, '0, 0);

        // Line 0 (with a gap between data beats), then the 0x1000 line
        do_write(64'h0000, 13'h0100, 64'h0123_4567_0000_0001, 4, 99);
        do_write(64'h1000, 13'h0100, 64'h11, 99, 99);

        // Read from an unaligned address inside the line
        do_read(64'h1008, 13'h1100, 99, 0, 0, '0, '0, 0, 64'h11, 7, 64'h88);

        // Beat 3 stalled for five cycles
        do_read(64'h1000, 13'h1123, 3, 5, 0, '0, '0, 3, 64'h44, 4, 64'h55);

        // Competing request during the burst, accepted right after it
        do_read(64'h1000, 13'h1100, 99, 0, 1, 64'h0010, 13'h1155, 2, 64'h33, 99, '0);
        do_read(64'h0010, 13'h1155, 99, 0, 0, '0, '0, 1, 64'h0246_8ACE_0000_0002, 99, '0);

        // Non-memory type: writes discarded, reads all-zero
        do_write(64'h1000, 13'h0200, 64'hDEAD, 99, 99);
        do_read(64'h1000, 13'h1200, 99, 0, 0, '0, '0, 0, 64'h0, 7, 64'h0);
        do_read(64'h1000, 13'h1100, 99, 0, 0, '0, '0, 0, 64'h11, 7, 64'h88);

        // Reset during data beat 2: words 0-1 new, 2-7 from the earlier line
        do_write(64'h2000, 13'h0100, 64'h0000_00A0_0000_0001, 99, 99);
        do_write(64'h2000, 13'h0100, 64'h0000_00B0_0000_0001, 99, 2);
        do_read(64'h2000, 13'h1100, 99, 0, 0, '0, '0, 1, 64'h0000_0160_0000_0002,
                2, 64'h0000_01E0_0000_0003);

        // Word index 4096: all-ones with range checking, wraps to line 0 without
`ifdef SYSBUS_ADDR_CHECK_EN
        do_read(64'h8000, 13'h1100, 99, 0, 0, '0, '0, 0, 64'hFFFF_FFFF_FFFF_FFFF,
                7, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        do_read(64'h8000, 13'h1100, 99, 0, 0, '0, '0, 0, 64'h0123_4567_0000_0001,
                7, 64'h091A_2B38_0000_0008);
`endif

        cyc(1, 0, '0, '0, 0, 0, 0, '0, '0, 0);
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sysbus_mem_responder.md
SYSBUS_MEM_RESPONDER -- requirements
Module: sysbus_mem_responder

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, bus data and memory word width in bits.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13, bus tag width in bits.
REQ-003 SHALL have parameter MEM_WORDS, default 4096, backing-store depth in words, power of two.
REQ-004 SHALL have parameter RESP_LATENCY, default 4, cycles from request accept to first response beat, range 1..15.
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 bus_reqcyc  in  1  request valid; bus_req  in  BUS_DATA_WIDTH  byte address, or write data beat; bus_reqtag  in  BUS_TAG_WIDTH  request tag.
REQ-008 bus_reqack  out  1  request or write beat accepted.
REQ-009 bus_respcyc  out  1  response beat valid; bus_resp  out  BUS_DATA_WIDTH  read data; bus_resptag  out  BUS_TAG_WIDTH  echoed request tag.
REQ-010 bus_respack  in  1  initiator consumed the current beat.
REQ-011 busy  out  1  high whenever state is not IDLE.

Function
REQ-012 Tag decode SHALL be: tag[12] 1=read, 0=write; tag[11:8] type; only type MEMORY (4'b0001) accesses the store.
REQ-013 States SHALL be IDLE, WR_DATA, WAIT_LAT, RESP.
REQ-014 bus_reqack SHALL be combinational: bus_reqcyc in IDLE or in WR_DATA, 0 in WAIT_LAT/RESP.
REQ-015 IDLE + bus_reqcyc: SHALL capture line base = bus_req with bits [5:0] cleared and capture the tag; read -> WAIT_LAT; write -> WR_DATA.
REQ-016 WR_DATA: each edge with bus_reqcyc high SHALL write bus_req to word base+beat and increment beat; after beat 7 SHALL return to IDLE; no response SHALL be issued for writes.
REQ-017 WAIT_LAT SHALL count RESP_LATENCY cycles, then enter RESP with beat=0.
REQ-018 RESP: bus_respcyc=1, bus_resp=word base+beat, bus_resptag=captured tag; beat SHALL advance only on an edge with bus_respack=1; after acknowledged beat 7, bus_respcyc SHALL be 0 the next cycle and state IDLE.
REQ-019 A burst SHALL be 8 beats in ascending word order; word index = byte address >> 3, modulo MEM_WORDS unless REQ-027 applies.
REQ-020 Non-MEMORY type SHALL be accepted as normal; reads return 8 all-zero beats; writes are discarded.
REQ-021 bus_respack while bus_respcyc=0 SHALL be ignored; bus_reqcyc in WAIT_LAT/RESP SHALL be held off (no ack) until IDLE.
REQ-022 Back-to-back: a request presented on the cycle RESP exits SHALL be accepted in the following IDLE cycle, earliest turnaround one cycle.

Reset
REQ-023 Reset assertion SHALL immediately force state IDLE, beat=0, latency counter=0, bus_respcyc=0, bus_resp=0, bus_resptag=0, bus_reqack=0, busy=0.
REQ-024 Reset mid-burst SHALL abort the burst; words already written SHALL remain; memory contents SHALL NOT be reset.
REQ-025 Deassertion SHALL take effect on the first rising clk edge after release.

Configuration
REQ-026 Macro SYSBUS_ADDR_CHECK_EN SHALL select range checking.
REQ-027 Defined: line base with word index >= MEM_WORDS SHALL return 8 all-ones beats on read and drop writes. Undefined: address SHALL wrap modulo MEM_WORDS.

Structure
REQ-028 Package sysbus_pkg SHALL hold the state enum, tag field positions, type constant MEMORY=4'b0001, and BEATS_PER_LINE=8.
REQ-029 Storage SHALL be one sub-module sysbus_mem_array, single-port, synchronous write, combinational read.

Verification
REQ-030 Write tag 13'b0_0001_0000_0000 at 0x1000, beats 0x11..0x88, then read tag 13'b1_0001_0000_0000 at 0x1008 -> 8 beats 0x11..0x88, resptag echoed, first beat 4 cycles after ack.
REQ-031 Read with bus_respack held low 5 cycles on beat 3 -> beat 3 data stable, bus_respcyc high throughout, no beat skipped.
REQ-032 Request during RESP -> bus_reqack 0 until IDLE, then accepted; both bursts correct.
REQ-033 Reset low during beat 2 of write -> outputs zero immediately; words 0-1 written, 2-7 unchanged.
REQ-034 Read with tag type 4'b0010 -> 8 zero beats, store unchanged.
REQ-035 Read at byte 0x8000 with MEM_WORDS=4096 -> all-ones beats with SYSBUS_ADDR_CHECK_EN; contents of 0x0000 line without.
